// File: rtl/frankie_io_pkg.sv
// -----------------------------------------------------------------------------
// frankie_io_pkg
// Shared constants and types for the Frankie I/O bridge.
//   WORD_W     : Frankie word size (fixed at 16 bits)
//   HOLD_CNT_W : width of the input-path hold counter
//   io_state_e : input-path state (idle / holding a word on core_io_in)
// -----------------------------------------------------------------------------
package frankie_io_pkg;

    localparam int WORD_W     = 16;
    localparam int HOLD_CNT_W = 16;

    typedef enum logic {
        IO_IDLE = 1'b0,
        IO_HOLD = 1'b1
    } io_state_e;

endpackage : frankie_io_pkg

// File: rtl/frankie_io_fifo.sv
// -----------------------------------------------------------------------------
// frankie_io_fifo
// Small synchronous FIFO with first-word-fall-through head output.
//   clock      : system clock, rising edge
//   reset      : asynchronous active-low reset (clears pointers, level, storage)
//   push       : write push_data at the tail (caller guarantees !full || pop)
//   push_data  : word to write
//   pop        : drop the head entry (caller guarantees !empty)
//   head_data  : current head entry, read combinationally from storage
//   full/empty : occupancy flags
//   level      : current occupancy, 0..DEPTH
// DEPTH must be a power of two (>= 2) so pointers wrap by natural overflow.
// -----------------------------------------------------------------------------
module frankie_io_fifo
    import frankie_io_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int WIDTH = WORD_W
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         head_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int AW = $clog2(DEPTH);

    logic [DEPTH-1:0][WIDTH-1:0] mem_q, mem_d;
    logic [AW-1:0]               wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]               rd_ptr_q, rd_ptr_d;
    logic [AW:0]                 level_q, level_d;

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;

        if (push) begin
            mem_d[wr_ptr_q] = push_data;
            wr_ptr_d        = wr_ptr_q + 1'b1;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end

        // Simultaneous push and pop leaves the occupancy unchanged.
        unique case ({push, pop})
            2'b10:   level_d = level_q + 1'b1;
            2'b01:   level_d = level_q - 1'b1;
            default: level_d = level_q;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            mem_q    <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
        end
    end

    assign head_data = mem_q[rd_ptr_q];
    assign full      = (level_q == (AW+1)'(DEPTH));
    assign empty     = (level_q == '0);
    assign level     = level_q;

endmodule : frankie_io_fifo

// File: rtl/frankie_io_bridge.sv
// -----------------------------------------------------------------------------
// frankie_io_bridge
// Bridges the Frankie core's io_in/io_out pins to a valid/ready bus.
//   Output path: every change of core_io_out is queued in a FIFO and offered
//                downstream on out_data/out_valid/out_ready.
//   Input path : an upstream word is driven onto core_io_in and held for
//                HOLD_CYCLES cycles (in_ready low) so the core can sample it.
// Ports:
//   clock, reset               : clock (rising edge), async active-low reset
//   core_io_out / core_io_in   : Frankie pins
//   in_data/in_valid/in_ready  : upstream input handshake
//   out_data/out_valid/out_ready : downstream output handshake
//   fifo_level                 : output FIFO occupancy
//   overflow / overflow_clr    : sticky dropped-event flag and its clear
//   drop_count                 : saturating 8-bit drop counter, present only
//                                when FRANKIE_IO_DROP_CNT_EN is defined
// -----------------------------------------------------------------------------
module frankie_io_bridge
    import frankie_io_pkg::*;
#(
    parameter int DEPTH       = 4,
    parameter int HOLD_CYCLES = 8
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic [WORD_W-1:0]        core_io_out,
    output logic [WORD_W-1:0]        core_io_in,
    input  logic [WORD_W-1:0]        in_data,
    input  logic                     in_valid,
    output logic                     in_ready,
    output logic [WORD_W-1:0]        out_data,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [$clog2(DEPTH):0]   fifo_level,
    output logic                     overflow,
`ifdef FRANKIE_IO_DROP_CNT_EN
    output logic [7:0]               drop_count,
`endif
    input  logic                     overflow_clr
);

    // ------------------------------------------------------------------
    // Output path: change detect, FIFO, overflow
    // ------------------------------------------------------------------
    logic [WORD_W-1:0] prev_out_q, prev_out_d;
    logic              overflow_q, overflow_d;
    logic              change_evt;
    logic              fifo_push;
    logic              fifo_pop;
    logic              fifo_full;
    logic              fifo_empty;
    logic              drop_evt;

    // prev_out resets to 0, matching the core's own reset value, so the
    // core coming out of reset produces no spurious event.
    assign change_evt = (core_io_out != prev_out_q);
    assign fifo_pop   = out_valid && out_ready;
    // A full FIFO still accepts a push when the head leaves in the same cycle.
    assign fifo_push  = change_evt && (!fifo_full || fifo_pop);
    assign drop_evt   = change_evt && fifo_full && !fifo_pop;

    always_comb begin
        prev_out_d = core_io_out;
        overflow_d = overflow_q;
        // Setting has priority over clearing so a drop is never lost.
        if (drop_evt) begin
            overflow_d = 1'b1;
        end else if (overflow_clr) begin
            overflow_d = 1'b0;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            prev_out_q <= '0;
            overflow_q <= 1'b0;
        end else begin
            prev_out_q <= prev_out_d;
            overflow_q <= overflow_d;
        end
    end

    frankie_io_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (WORD_W)
    ) u_fifo (
        .clock     (clock),
        .reset     (reset),
        .push      (fifo_push),
        .push_data (core_io_out),
        .pop       (fifo_pop),
        .head_data (out_data),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .level     (fifo_level)
    );

    assign out_valid = !fifo_empty;
    assign overflow  = overflow_q;

`ifdef FRANKIE_IO_DROP_CNT_EN
    logic [7:0] drop_count_q, drop_count_d;

    always_comb begin
        drop_count_d = drop_count_q;
        if (drop_evt) begin
            // A clear coinciding with a drop restarts the count at that drop.
            if (overflow_clr) begin
                drop_count_d = 8'd1;
            end else if (drop_count_q != 8'hFF) begin
                drop_count_d = drop_count_q + 8'd1;
            end
        end else if (overflow_clr) begin
            drop_count_d = 8'd0;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            drop_count_q <= 8'd0;
        end else begin
            drop_count_q <= drop_count_d;
        end
    end

    assign drop_count = drop_count_q;
`endif

    // ------------------------------------------------------------------
    // Input path: accept a word, then throttle for HOLD_CYCLES cycles
    // ------------------------------------------------------------------
    io_state_e             state_q, state_d;
    logic [HOLD_CNT_W-1:0] hold_cnt_q, hold_cnt_d;
    logic [WORD_W-1:0]     core_io_in_q, core_io_in_d;

    always_comb begin
        state_d      = state_q;
        hold_cnt_d   = hold_cnt_q;
        core_io_in_d = core_io_in_q;
        in_ready     = 1'b0;

        unique case (state_q)
            IO_IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    core_io_in_d = in_data;
                    if (HOLD_CYCLES != 0) begin
                        hold_cnt_d = HOLD_CNT_W'(HOLD_CYCLES);
                        state_d    = IO_HOLD;
                    end
                end
            end
            IO_HOLD: begin
                // Leaving on count 1 makes in_ready rise exactly HOLD_CYCLES
                // edges after the accepting edge.
                if (hold_cnt_q == HOLD_CNT_W'(1)) begin
                    hold_cnt_d = '0;
                    state_d    = IO_IDLE;
                end else begin
                    hold_cnt_d = hold_cnt_q - 1'b1;
                end
            end
            default: begin
                state_d    = IO_IDLE;
                hold_cnt_d = '0;
            end
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q      <= IO_IDLE;
            hold_cnt_q   <= '0;
            core_io_in_q <= '0;
        end else begin
            state_q      <= state_d;
            hold_cnt_q   <= hold_cnt_d;
            core_io_in_q <= core_io_in_d;
        end
    end

    assign core_io_in = core_io_in_q;

endmodule : frankie_io_bridge

// File: tb/tb_frankie_io_bridge.sv
// -----------------------------------------------------------------------------
// tb_frankie_io_bridge
// Self-checking bench for frankie_io_bridge (DEPTH=4, HOLD_CYCLES=8).
// Output path is checked by a scoreboard: a monitor on the falling edge
// models change detection, pushes expected words and pops/compares them as
// the DUT hands them downstream. The input path is checked from a table.
// Define FRANKIE_IO_DROP_CNT_EN to also exercise drop_count.
// -----------------------------------------------------------------------------
module tb_frankie_io_bridge;
    import frankie_io_pkg::*;

    localparam int DEPTH       = 4;
    localparam int HOLD_CYCLES = 8;

    logic                    clock = 1'b0;
    logic                    reset = 1'b0;
    logic [WORD_W-1:0]       core_io_out = '0;
    logic [WORD_W-1:0]       core_io_in;
    logic [WORD_W-1:0]       in_data = '0;
    logic                    in_valid = 1'b0;
    logic                    in_ready;
    logic [WORD_W-1:0]       out_data;
    logic                    out_valid;
    logic                    out_ready = 1'b0;
    logic [$clog2(DEPTH):0]  fifo_level;
    logic                    overflow;
    logic                    overflow_clr = 1'b0;
`ifdef FRANKIE_IO_DROP_CNT_EN
    logic [7:0]              drop_count;
`endif

    frankie_io_bridge #(
        .DEPTH       (DEPTH),
        .HOLD_CYCLES (HOLD_CYCLES)
    ) dut (
        .clock        (clock),
        .reset        (reset),
        .core_io_out  (core_io_out),
        .core_io_in   (core_io_in),
        .in_data      (in_data),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .out_data     (out_data),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .fifo_level   (fifo_level),
        .overflow     (overflow),
`ifdef FRANKIE_IO_DROP_CNT_EN
        .drop_count   (drop_count),
`endif
        .overflow_clr (overflow_clr)
    );

    always #5 clock = ~clock;

    int vec_count  = 0;
    int fail_count = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vec_count++;
        if (act !== exp) begin
            fail_count++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end else begin
            $display("ok   %s: 0x%0h", name, act);
        end
    endtask

    task automatic tick(input int n = 1);
        for (int i = 0; i < n; i++) begin
            @(posedge clock);
            #1;
        end
    endtask

    // ------------------------------------------------------------------
    // Output-path scoreboard
    // ------------------------------------------------------------------
    logic [WORD_W-1:0] exp_q[$];
    logic [WORD_W-1:0] model_prev = '0;
    bit                mon_en = 1'b0;
    int                pop_count = 0;

    always @(negedge clock) begin
        if (mon_en) begin
            chk("sb_level", 32'(fifo_level), 32'(exp_q.size()));
            chk("sb_valid", 32'(out_valid), 32'(exp_q.size() != 0));
            if (exp_q.size() != 0 && out_ready) begin
                chk("sb_data", 32'(out_data), 32'(exp_q[0]));
                void'(exp_q.pop_front());
                pop_count++;
            end
            if (core_io_out != model_prev) begin
                if (exp_q.size() < DEPTH) exp_q.push_back(core_io_out);
            end
            model_prev = core_io_out;
        end
    end

    // ------------------------------------------------------------------
    // Input-path vector table: drive, clock once, compare after the edge
    // ------------------------------------------------------------------
    typedef struct {
        logic              valid;
        logic [WORD_W-1:0] data;
        logic              exp_ready;
        logic [WORD_W-1:0] exp_io_in;
    } in_vec_t;

    in_vec_t in_tbl[12];

    initial begin
        // Accept 0x00A5, hold 8 cycles while 0x5A00 is offered, then accept it.
        in_tbl[0] = '{1'b1, 16'h00A5, 1'b0, 16'h00A5};
        for (int k = 1; k <= 7; k++) in_tbl[k] = '{1'b1, 16'h5A00, 1'b0, 16'h00A5};
        in_tbl[8]  = '{1'b1, 16'h5A00, 1'b1, 16'h00A5};
        in_tbl[9]  = '{1'b1, 16'h5A00, 1'b0, 16'h5A00};
        in_tbl[10] = '{1'b0, 16'h0000, 1'b0, 16'h5A00};
        in_tbl[11] = '{1'b0, 16'hFFFF, 1'b0, 16'h5A00};

        // ---------------- reset, idle core ----------------
        #2;
        chk("rst_core_io_in", 32'(core_io_in), 32'h0);
        chk("rst_in_ready",   32'(in_ready),   32'h1);
        chk("rst_out_valid",  32'(out_valid),  32'h0);
        chk("rst_out_data",   32'(out_data),   32'h0);
        chk("rst_overflow",   32'(overflow),   32'h0);
        tick();
        reset  = 1'b1;
        mon_en = 1'b1;
        tick(10);
        chk("idle_out_valid",  32'(out_valid),  32'h0);
        chk("idle_fifo_level", 32'(fifo_level), 32'h0);
        chk("idle_in_ready",   32'(in_ready),   32'h1);
        chk("idle_core_io_in", 32'(core_io_in), 32'h0);

        // ---------------- two changes, streaming ----------------
        out_ready   = 1'b1;
        pop_count   = 0;
        core_io_out = 16'h1234;
        tick();
        chk("chg1_valid", 32'(out_valid), 32'h1);
        chk("chg1_data",  32'(out_data),  32'h1234);
        tick();
        core_io_out = 16'hBEEF;
        tick();
        chk("chg2_valid", 32'(out_valid), 32'h1);
        chk("chg2_data",  32'(out_data),  32'hBEEF);
        tick(3);
        chk("chg_pops", 32'(pop_count), 32'd2);

        // ---------------- overflow: six changes, no drain ----------------
        out_ready = 1'b0;
        for (int k = 1; k <= 6; k++) begin
            core_io_out = 16'(k * 16'h1111);
            tick();
        end
        chk("ovf_level", 32'(fifo_level), 32'd4);
        chk("ovf_flag",  32'(overflow),   32'h1);
`ifdef FRANKIE_IO_DROP_CNT_EN
        chk("ovf_drops", 32'(drop_count), 32'd2);
`endif
        overflow_clr = 1'b1;
        tick();
        overflow_clr = 1'b0;
        chk("clr_alone_flag", 32'(overflow), 32'h0);
`ifdef FRANKIE_IO_DROP_CNT_EN
        chk("clr_alone_drops", 32'(drop_count), 32'd0);
`endif

        // ---------------- full + pop + change: no drop ----------------
        out_ready   = 1'b1;
        core_io_out = 16'h7777;
        tick();
        out_ready   = 1'b0;
        chk("fullpop_level", 32'(fifo_level), 32'd4);
        chk("fullpop_flag",  32'(overflow),   32'h0);

        // ---------------- clear together with a drop ----------------
        core_io_out  = 16'h8888;
        overflow_clr = 1'b1;
        tick();
        overflow_clr = 1'b0;
        chk("clr_drop_flag", 32'(overflow), 32'h1);
`ifdef FRANKIE_IO_DROP_CNT_EN
        chk("clr_drop_drops", 32'(drop_count), 32'd1);
`endif
        overflow_clr = 1'b1;
        tick();
        overflow_clr = 1'b0;
        chk("clr2_flag", 32'(overflow), 32'h0);

        // ---------------- drain ----------------
        out_ready = 1'b1;
        tick(6);
        chk("drain_level", 32'(fifo_level), 32'd0);
        chk("drain_left",  32'(exp_q.size()), 32'd0);

        // ---------------- input path table ----------------
        for (int i = 0; i < 12; i++) begin
            in_valid = in_tbl[i].valid;
            in_data  = in_tbl[i].data;
            tick();
            chk($sformatf("in%0d_ready", i), 32'(in_ready),   32'(in_tbl[i].exp_ready));
            chk($sformatf("in%0d_io_in", i), 32'(core_io_in), 32'(in_tbl[i].exp_io_in));
        end

        // ---------------- asynchronous reset mid-operation ----------------
        core_io_out = 16'h4242;          // one item queued with no drain
        out_ready   = 1'b0;
        tick(2);
        #2;
        mon_en = 1'b0;
        reset  = 1'b0;
        #1;
        chk("arst_core_io_in", 32'(core_io_in), 32'h0);
        chk("arst_in_ready",   32'(in_ready),   32'h1);
        chk("arst_out_valid",  32'(out_valid),  32'h0);
        chk("arst_level",      32'(fifo_level), 32'h0);
        core_io_out = '0;
        exp_q.delete();
        model_prev = '0;
        tick();
        reset  = 1'b1;
        mon_en = 1'b1;
        tick(3);
        chk("post_rst_in_ready", 32'(in_ready), 32'h1);

        $display("== %0d vectors applied, %0d miscompares ==", vec_count, fail_count);
        $finish;
    end

    // Hard bound so the run always ends.
    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

endmodule : tb_frankie_io_bridge
